// File: rtl/mem_port_arbiter.sv
// Arbiter for a single-ported unified I/D memory: MEM has priority, IF is protected by a
// starvation guard, and each access holds the port for MEM_LAT cycles before a one-cycle DONE.
module mem_port_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int MEM_LAT      = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_valid,
  output logic              mem_stall,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-3:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam int LAT_W = $clog2(MEM_LAT + 1);
  localparam int STK_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM, DONE} state_t;

  state_t           state, state_nxt;
  logic [LAT_W-1:0] lat_cnt;
  logic [STK_W-1:0] streak;
  logic             owner_if;
  logic             discard;
  logic             we_q;
  logic             grant_mem, grant_if, last_beat;

  // Memory is word-addressed; byte-offset bits of the requester addresses are dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[1:0], mem_addr[1:0]};

  // NOTE: every signal driven here gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_nxt = state;
    grant_mem = 1'b0;
    grant_if  = 1'b0;
    last_beat = (lat_cnt == LAT_W'(MEM_LAT));
    unique case (state)
      IDLE: begin
        if (mem_req && (!if_req || streak < STK_W'(STARVE_LIMIT))) begin
          grant_mem = 1'b1;
          state_nxt = BUSY_MEM;
        end else if (if_req && !if_flush) begin
          grant_if  = 1'b1;
          state_nxt = BUSY_IF;
        end
      end
      BUSY_IF, BUSY_MEM: if (last_beat) state_nxt = DONE;
      // No re-arbitration here: a request still held from the finished access must not be re-granted.
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    m_en      = (state == BUSY_IF) || (state == BUSY_MEM);
    m_we      = (state == BUSY_MEM) && we_q;
    if_valid  = (state == DONE) && owner_if && !discard && !if_flush;
    mem_valid = (state == DONE) && !owner_if;
    if_stall  = if_req && !if_valid;
    mem_stall = mem_req && !mem_valid;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: every register here is a plain flop, so all of them are reset; there is no memory array to exempt.
      state     <= IDLE;
      lat_cnt   <= '0;
      streak    <= '0;
      owner_if  <= 1'b0;
      discard   <= 1'b0;
      we_q      <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
      if_rdata  <= '0;
      mem_rdata <= '0;
    end else begin
      state <= state_nxt;

      if (grant_mem || grant_if) begin
        lat_cnt  <= LAT_W'(1);
        owner_if <= grant_if;
        discard  <= 1'b0;
        we_q     <= grant_mem && mem_we;
        m_addr   <= grant_if ? if_addr[ADDR_W-1:2] : mem_addr[ADDR_W-1:2];
        if (grant_mem) m_wdata <= mem_wdata;
      end else if (m_en) begin
        lat_cnt <= last_beat ? '0 : lat_cnt + LAT_W'(1);
      end

      // A flushed fetch still runs to completion on the memory side; only its result is dropped.
      if (state == BUSY_IF && if_flush) discard <= 1'b1;
      if (state == BUSY_IF && last_beat && !discard && !if_flush) if_rdata <= m_rdata;
      if (state == BUSY_MEM && last_beat && !we_q) mem_rdata <= m_rdata;

      if (grant_if) begin
        streak <= '0;
      end else if (grant_mem) begin
        if (!if_req) streak <= '0;
        else if (streak < STK_W'(STARVE_LIMIT)) streak <= streak + STK_W'(1);
      end
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported unified instruction/data memory between instruction fetch (IF requester) and load/store (MEM requester; driven from decoded readmem/writemem).
- Sequences each access over a fixed memory latency and returns data.
- Raises per-requester stall lines so the pipeline freezes while an access is pending.
- Fixed priority to MEM (older instruction), with a starvation guard for IF.

Parameters:
DATA_W, 32, data width of memory and both requesters
ADDR_W, 32, byte-address width; memory takes word address ADDR_W-2 bits
MEM_LAT, 2, cycles the memory port must be held per access (>=1)
STARVE_LIMIT, 4, max consecutive MEM grants while if_req pending before IF is forced (>=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request, level, held until if_valid or if_flush
if_addr  in  ADDR_W  fetch byte address (PC)
if_flush  in  1  branch/jump taken: cancel pending/in-flight fetch
if_rdata  out  DATA_W  fetched instruction, registered
if_valid  out  1  one-cycle pulse: if_rdata valid, fetch complete
if_stall  out  1  if_req & ~if_valid (combinational)
mem_req  in  1  load/store request, level, held until mem_valid
mem_we  in  1  1 = store, 0 = load; stable while mem_req high
mem_addr  in  ADDR_W  data byte address
mem_wdata  in  DATA_W  store data
mem_rdata  out  DATA_W  load data, registered
mem_valid  out  1  one-cycle pulse: access complete
mem_stall  out  1  mem_req & ~mem_valid (combinational)
m_en  out  1  memory enable, high for exactly MEM_LAT cycles per access
m_we  out  1  memory write enable (only with m_en)
m_addr  out  ADDR_W-2  word address = granted addr[ADDR_W-1:2]; low 2 bits ignored
m_wdata  out  DATA_W  write data
m_rdata  in  DATA_W  memory read data, valid on last m_en cycle

Behaviour:
- Reset (async, rst_n=0): state IDLE; m_en, m_we, if_valid, mem_valid = 0; m_addr, m_wdata, if_rdata, mem_rdata = 0; lat_cnt, streak = 0. An in-flight access is abandoned and m_en drops immediately.
- States IDLE, BUSY_IF, BUSY_MEM, DONE.
- IDLE arbitration, evaluated each cycle:
  - mem_req & (~if_req | streak<STARVE_LIMIT) -> BUSY_MEM.
  - Else if_req & ~if_flush -> BUSY_IF.
  - Else stay.
  - Granted addr/we/wdata are latched into output registers at the grant edge.
- BUSY_x: m_en=1, m_we=mem_we (BUSY_MEM only), lat_cnt counts 1..MEM_LAT.
  - At the edge ending cycle MEM_LAT: capture m_rdata into if_rdata (BUSY_IF) or mem_rdata (BUSY_MEM load), then go to DONE.
  - Stores leave mem_rdata unchanged.
- DONE: pulse the matching valid for one cycle; m_en=0; always return to IDLE (no re-arbitration in DONE, so a stale held request is never re-granted).
- Latency: request seen in IDLE at cycle 0 -> m_en cycles 1..MEM_LAT -> valid in cycle MEM_LAT+1. Throughput: one access per MEM_LAT+2 cycles.
- Starvation counter (streak):
  - +1 on each MEM grant made while if_req=1 (saturating at STARVE_LIMIT).
  - Cleared on IF grant, or when if_req=0 at a MEM grant.
- Flush:
  - if_flush in BUSY_IF: access completes on the memory side (m_en still held MEM_LAT cycles), but a discard flag is set. In DONE, if_valid stays 0 and if_rdata is not updated.
  - if_flush in DONE for an IF access also suppresses if_valid.
  - if_flush has no effect on MEM accesses.
- Simultaneous if_req & mem_req in IDLE with streak<STARVE_LIMIT: MEM wins; IF waits (if_stall=1).
- Requests dropped mid-access (protocol violation) are ignored; the access completes and valid still pulses.

Test Plan:
- MEM_LAT=2, if_req alone, if_addr=0x0000_0010, memory returns 0x2008_0005 -> m_en cycles 1-2 with m_addr=0x4; if_valid pulse cycle 3 with if_rdata=0x2008_0005; if_stall high cycles 0-2.
- Both requests cycle 0: mem load addr 0x100, if addr 0x20 -> MEM served first (mem_valid cycle 3); IF granted cycle 4, if_valid cycle 7.
- STARVE_LIMIT=2, mem_req and if_req held continuously (MEM re-requests right after each valid) -> grant order MEM, MEM, IF, MEM, MEM, IF; streak resets after each IF grant.
- Store mem_we=1, addr 0x40, wdata 0xDEAD_BEEF -> m_we=m_en=1 for 2 cycles with m_addr=0x10; mem_valid pulse; mem_rdata unchanged from previous load.
- if_flush asserted cycle 2 during BUSY_IF -> m_en still 2 cycles; no if_valid; if_rdata keeps old value; next IDLE grants new PC.
- rst_n low during cycle 1 of BUSY_MEM -> m_en=0 immediately, all outputs 0; after release, pending mem_req re-granted from IDLE.
